// File: rtl/chess_move_pkg.sv
// Shared move/word layout for the column drain path: slot geometry, flag bit
// positions, FSM state type and the end-of-column marker predicate.
package chess_move_pkg;

   localparam int unsigned MOVE_W = 19;
   localparam int unsigned SLOTS  = 8;
   localparam int unsigned WORD_W = MOVE_W * SLOTS;
   localparam int unsigned NCOLS  = 8;
   localparam int unsigned SQ_W   = 6;

   localparam int unsigned FLAG_INVALID    = 18;
   localparam int unsigned FLAG_PROMOTE    = 17;
   localparam int unsigned FLAG_PAWN_MOVE  = 16;
   localparam int unsigned FLAG_PAWN_2SQ   = 15;
   localparam int unsigned FLAG_EN_PASSANT = 14;
   localparam int unsigned FLAG_CASTLE     = 13;
   localparam int unsigned FLAG_CAPTURE    = 12;

   typedef logic [MOVE_W-1:0] move_t;
   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SCAN,
      ST_REQ,
      ST_LATCH,
      ST_EMIT,
      ST_FIN
   } state_t;

   // A column is finished when every slot is invalid and is a null move.
   function automatic logic is_end_marker(input word_t w);
      logic  m;
      move_t s;
      m = 1'b1;
      for (int unsigned k = 0; k < SLOTS; k++) begin
         s = w[k*MOVE_W +: MOVE_W];
         if (!s[FLAG_INVALID] || (s[2*SQ_W-1:SQ_W] != s[SQ_W-1:0]))
            m = 1'b0;
      end
      return m;
   endfunction

endpackage

// File: rtl/move_word_unpacker.sv
// Combinational slot select by pointer, with invalid-slot and end-marker decode.
module move_word_unpacker
   import chess_move_pkg::*;
(
   input  word_t       word,
   input  logic [2:0]  ptr,
   output move_t       slot,
   output logic        slot_invalid,
   output logic        end_marker
);

   move_t slots [SLOTS];

   always_comb begin
      for (int unsigned k = 0; k < SLOTS; k++)
         slots[k] = word[k*MOVE_W +: MOVE_W];
      slot         = slots[ptr];
      slot_invalid = slot[FLAG_INVALID];
      end_marker   = is_end_marker(word);
   end

endmodule

// File: rtl/column_move_drain.sv
// Drains per-column move FIFOs in column order, presenting one move at a time
// on a valid/ready port and counting accepted moves for the pass.
module column_move_drain
   import chess_move_pkg::*;
#(
   parameter int unsigned CNT_W = 8
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [NCOLS-1:0]        col_done,
   input  logic [NCOLS*WORD_W-1:0] col_word,
   output logic [NCOLS-1:0]        col_rden,
   output logic                    mv_valid,
   output logic [MOVE_W-1:0]       mv_data,
   input  logic                    mv_ready,
   output logic [CNT_W-1:0]        move_count,
   output logic                    busy,
   output logic                    all_done
);

   state_t           state, state_nx;
   logic [NCOLS-1:0] drained;
   logic [NCOLS-1:0] cand;
   logic [2:0]       sel;
   logic [2:0]       pick;
   logic [2:0]       ptr;
   word_t            word_q;
   word_t            col_words [NCOLS];
   word_t            col_sel_word;
   word_t            unp_word;
   move_t            slot;
   logic             slot_invalid;
   logic             end_marker;
   logic             advance;
   logic             accept;

   always_comb begin
      for (int unsigned i = 0; i < NCOLS; i++)
         col_words[i] = col_word[i*WORD_W +: WORD_W];
      col_sel_word = col_words[sel];
   end

   // In LATCH the decoder looks at the word arriving from the FIFO so the
   // end-marker decision is made in the same cycle the word is registered.
   assign unp_word = (state == ST_LATCH) ? col_sel_word : word_q;

   move_word_unpacker u_unpack (
      .word         (unp_word),
      .ptr          (ptr),
      .slot         (slot),
      .slot_invalid (slot_invalid),
      .end_marker   (end_marker)
   );

   always_comb begin
      cand = col_done & ~drained;
      pick = '0;
      for (int unsigned i = NCOLS; i > 0; i--)
         if (cand[i-1]) pick = 3'(i - 1);
   end

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      col_rden = '0;
      mv_valid = 1'b0;
      mv_data  = '0;
      busy     = (state != ST_IDLE);
      advance  = 1'b0;
      case (state)
         ST_IDLE:  if (start) state_nx = ST_SCAN;
         ST_SCAN: begin
            if (&drained)   state_nx = ST_FIN;
            else if (|cand) state_nx = ST_REQ;
         end
         ST_REQ: begin
            col_rden[sel] = 1'b1;
            state_nx      = ST_LATCH;
         end
         ST_LATCH: state_nx = end_marker ? ST_SCAN : ST_EMIT;
         ST_EMIT: begin
            mv_valid = !slot_invalid;
            if (!slot_invalid) mv_data = slot;
            advance  = slot_invalid || mv_ready;
            if (advance && (ptr == 3'd0)) state_nx = ST_REQ;
         end
         ST_FIN:   state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   assign accept = mv_valid && mv_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         drained    <= '0;
         sel        <= '0;
         word_q     <= '0;
         ptr        <= 3'd7;
         move_count <= '0;
         all_done   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  drained    <= '0;
                  move_count <= '0;
                  all_done   <= 1'b0;
               end
            end
            ST_SCAN: begin
               if (!(&drained) && (|cand)) sel <= pick;
            end
            ST_LATCH: begin
               word_q <= col_sel_word;
               ptr    <= 3'd7;
               if (end_marker) drained[sel] <= 1'b1;
            end
            ST_EMIT: begin
               if (advance) ptr <= ptr - 3'd1;
               if (accept && (move_count != '1)) move_count <= move_count + 1'b1;
            end
            ST_FIN:  all_done <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_column_move_drain.sv
// Randomised scoreboard bench for column_move_drain, with a saturating-counter
// twin instance sharing the same stimulus.
module tb_column_move_drain;
   import chess_move_pkg::*;

   localparam int NC = 8;
   localparam int WW = 152;

   logic              clk = 1'b0;
   logic              reset, start, mv_ready;
   logic [NC-1:0]     col_done;
   logic [NC*WW-1:0]  col_word;
   logic [NC-1:0]     col_rden, col_rden2;
   logic              mv_valid, mv_valid2;
   logic [18:0]       mv_data, mv_data2;
   logic [7:0]        move_count;
   logic [1:0]        move_count2;
   logic              busy, busy2, all_done, all_done2;

   column_move_drain #(.CNT_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .col_done(col_done), .col_word(col_word),
      .col_rden(col_rden), .mv_valid(mv_valid), .mv_data(mv_data), .mv_ready(mv_ready),
      .move_count(move_count), .busy(busy), .all_done(all_done));

   column_move_drain #(.CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .start(start), .col_done(col_done), .col_word(col_word),
      .col_rden(col_rden2), .mv_valid(mv_valid2), .mv_data(mv_data2), .mv_ready(mv_ready),
      .move_count(move_count2), .busy(busy2), .all_done(all_done2));

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [18:0] exp_q[$];
   logic [18:0] col_exp[NC][$];
   logic [WW-1:0] fifo_q[NC][$];
   int          exp_rd[NC];
   int          got_rd[NC];
   int          exp_total;
   int          ready_pct  = 100;
   bit          stall_first = 1'b0;
   bit          stall_seen  = 1'b0;
   bit          hold_pend   = 1'b0;
   logic [18:0] hold_data;
   logic [WW-1:0] end_w;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
      end
   endtask

   function automatic logic [WW-1:0] rand_word(input int pvalid);
      logic [WW-1:0] w;
      bit            any_valid;
      any_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         bit inv;
         inv = ($urandom_range(0, 99) >= pvalid);
         if (!inv) any_valid = 1'b1;
         w[k*19 +: 19] = {inv, 6'($urandom), 6'($urandom), 6'($urandom)};
      end
      if (!any_valid) w[5:0] = w[11:6] + 6'd1;
      return w;
   endfunction

   task automatic add_word(input int c, input logic [WW-1:0] w);
      logic [18:0] s;
      fifo_q[c].push_back(w);
      exp_rd[c]++;
      for (int k = 7; k >= 0; k--) begin
         s = w[k*19 +: 19];
         if (!s[18]) begin
            col_exp[c].push_back(s);
            exp_total++;
         end
      end
   endtask

   task automatic clear_pass();
      exp_q.delete();
      exp_total = 0;
      for (int c = 0; c < NC; c++) begin
         fifo_q[c].delete();
         col_exp[c].delete();
         exp_rd[c] = 0;
         got_rd[c] = 0;
      end
   endtask

   // Every column ends with a marker; moves are expected in ascending column order.
   task automatic finish_setup();
      for (int c = 0; c < NC; c++) begin
         fifo_q[c].push_back(end_w);
         exp_rd[c]++;
         while (col_exp[c].size() > 0) exp_q.push_back(col_exp[c].pop_front());
      end
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (!all_done && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!all_done) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: all_done=%0b after %0d cycles, required 1", tag, all_done, n);
      end
   endtask

   task automatic end_pass(input string tag);
      int e;
      @(negedge clk);
      e = exp_total;
      check($sformatf("%s_queue_left", tag), 64'(exp_q.size()), 64'(0));
      for (int c = 0; c < NC; c++)
         check($sformatf("%s_rden_col%0d", tag, c), 64'(got_rd[c]), 64'(exp_rd[c]));
      check($sformatf("%s_move_count", tag), 64'(move_count), 64'((e > 255) ? 255 : e));
      check($sformatf("%s_move_count_sat", tag), 64'(move_count2), 64'((e > 3) ? 3 : e));
      check($sformatf("%s_all_done", tag), 64'(all_done), 64'(1));
      check($sformatf("%s_busy", tag), 64'(busy), 64'(0));
   endtask

   task automatic check_outputs_zero(input string tag);
      check($sformatf("%s_col_rden", tag), 64'(col_rden), 64'(0));
      check($sformatf("%s_mv_valid", tag), 64'(mv_valid), 64'(0));
      check($sformatf("%s_mv_data", tag), 64'(mv_data), 64'(0));
      check($sformatf("%s_move_count", tag), 64'(move_count), 64'(0));
      check($sformatf("%s_busy", tag), 64'(busy), 64'(0));
      check($sformatf("%s_all_done", tag), 64'(all_done), 64'(0));
   endtask

   // Column FIFO model: one-cycle read latency.
   initial begin
      int idx;
      logic [WW-1:0] w;
      col_word = '0;
      forever begin
         @(negedge clk);
         if (!reset && col_rden != '0) begin
            idx = 0;
            for (int i = NC - 1; i >= 0; i--) if (col_rden[i]) idx = i;
            @(posedge clk); #1;
            w = (fifo_q[idx].size() > 0) ? fifo_q[idx].pop_front() : end_w;
            col_word[idx*WW +: WW] = w;
         end
      end
   end

   // Consumer ready driver, with an optional 5-cycle stall on the first move.
   initial begin
      logic [18:0] hd;
      logic [7:0]  hc;
      mv_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (stall_first && mv_valid && !reset) begin
            stall_first = 1'b0;
            hd = mv_data;
            hc = move_count;
            mv_ready = 1'b0;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               check("stall_valid", 64'(mv_valid), 64'(1));
               check("stall_data", 64'(mv_data), 64'(hd));
               check("stall_count", 64'(move_count), 64'(hc));
               if (k < 4) begin @(posedge clk); #1; end
            end
            stall_seen = 1'b1;
         end else begin
            mv_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
         end
      end
   end

   // Monitor: read-enable shape, hold stability and scoreboard compare.
   always @(negedge clk) begin
      logic [18:0] e;
      if (reset) begin
         hold_pend = 1'b0;
      end else begin
         if (col_rden != '0) begin
            check("rden_onehot", 64'($onehot(col_rden)), 64'(1));
            for (int i = 0; i < NC; i++) if (col_rden[i]) got_rd[i]++;
         end
         if (hold_pend) begin
            check("hold_valid", 64'(mv_valid), 64'(1));
            check("hold_data", 64'(mv_data), 64'(hold_data));
         end
         if (mv_valid && mv_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_move: got 0x%0h, required no move", mv_data);
            end else begin
               e = exp_q.pop_front();
               check("move_data", 64'(mv_data), 64'(e));
            end
         end
         hold_pend = mv_valid && !mv_ready;
         hold_data = mv_data;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WW-1:0] w;
      int n;
      for (int k = 0; k < 8; k++) end_w[k*19 +: 19] = 19'h40000;
      reset = 1'b1; start = 1'b0; col_done = '0;
      clear_pass();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_outputs_zero("reset");

      // Two done columns, one move each; pass finishes only once the rest are done.
      clear_pass();
      w = end_w;
      w[7*19 +: 19] = 19'h00208;
      add_word(0, w);
      add_word(3, w);
      finish_setup();
      col_done = 8'b0000_1001;
      ready_pct = 100;
      pulse_start();
      n = 0;
      while (exp_q.size() > 0 && n < 200) begin @(negedge clk); n++; end
      repeat (20) @(negedge clk);
      check("partial_all_done", 64'(all_done), 64'(0));
      check("partial_busy", 64'(busy), 64'(1));
      check("partial_count", 64'(move_count), 64'(2));
      check("partial_rden_col0", 64'(got_rd[0]), 64'(2));
      col_done = 8'hFF;
      wait_done("two_cols", 500);
      end_pass("two_cols");

      // Full word on column 2 with a stalled consumer on the first move.
      clear_pass();
      add_word(2, rand_word(100));
      add_word(6, rand_word(50));
      finish_setup();
      col_done = 8'hFF;
      stall_seen = 1'b0;
      stall_first = 1'b1;
      pulse_start();
      wait_done("full_word", 500);
      check("stall_happened", 64'(stall_seen), 64'(1));
      end_pass("full_word");

      // Late col_done on column 5, dropped again mid-drain.
      clear_pass();
      add_word(5, rand_word(70));
      add_word(5, rand_word(70));
      finish_setup();
      col_done = '0;
      ready_pct = 50;
      pulse_start();
      repeat (20) @(negedge clk);
      check("late_no_rden", 64'(got_rd[0] + got_rd[1] + got_rd[2] + got_rd[3] +
                               got_rd[4] + got_rd[5] + got_rd[6] + got_rd[7]), 64'(0));
      check("late_busy", 64'(busy), 64'(1));
      col_done = 8'h20;
      repeat (4) @(negedge clk);
      col_done = 8'h00;
      repeat (30) @(negedge clk);
      col_done = 8'hFF;
      wait_done("late_col", 2000);
      end_pass("late_col");

      // Randomised passes; a second start is pulsed mid-pass in one of them.
      for (int p = 0; p < 4; p++) begin
         clear_pass();
         for (int c = 0; c < NC; c++) begin
            int nw;
            nw = $urandom_range(0, 2);
            for (int j = 0; j < nw; j++) add_word(c, rand_word($urandom_range(0, 100)));
         end
         finish_setup();
         col_done = 8'hFF;
         ready_pct = $urandom_range(40, 100);
         pulse_start();
         if (p == 1) begin
            repeat (10) @(negedge clk);
            if (busy) pulse_start();
         end
         wait_done($sformatf("rand%0d", p), 5000);
         end_pass($sformatf("rand%0d", p));
      end

      // Reset during EMIT, then a fresh pass from column 0.
      clear_pass();
      add_word(1, rand_word(100));
      finish_setup();
      col_done = 8'hFF;
      ready_pct = 30;
      pulse_start();
      n = 0;
      while (!mv_valid && n < 100) begin @(negedge clk); n++; end
      check("reset_reached_emit", 64'(mv_valid), 64'(1));
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_outputs_zero("midreset");
      @(posedge clk); #1 reset = 1'b0;
      clear_pass();
      add_word(0, rand_word(80));
      add_word(4, rand_word(80));
      finish_setup();
      ready_pct = 100;
      @(negedge clk);
      check("post_reset_idle_count", 64'(move_count), 64'(0));
      pulse_start();
      wait_done("after_reset", 1000);
      end_pass("after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
